// File: rtl/ifetch_prefetch_pkg.sv
// Shared constants and helpers for the prefetching instruction-fetch unit.
// Optional ROM programming port: define IFETCH_PROG_EN.
package ifetch_prefetch_pkg;

  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ifetch_prefetch_inst_fifo.sv
// Synchronous FIFO holding {pc, instruction} pairs for the fetch unit.
// Depth must be a power of two so the pointers wrap for free.
module inst_fifo
  import ifetch_prefetch_pkg::*;
#(
  parameter  int W     = 64,
  parameter  int DEPTH = 4,
  localparam int PW    = ptr_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [PW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      unique case (1'b1)
        (do_push & ~do_pop): cnt_d = cnt_q + (PW+1)'(1);
        (do_pop & ~do_push): cnt_d = cnt_q - (PW+1)'(1);
        default:             cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage carries no reset; validity is tracked by cnt_q alone
  always_ff @(posedge clk_i) begin
    if (!flush_i && do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction fetch with prefetch queue between a 1-cycle ROM and decode.
// Define IFETCH_PROG_EN to add the ROM programming (upg_*) port.
module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int ROM_AW = 14,
  parameter int QDEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inited,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              dec_ready,
  output logic              inst_valid,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_link,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_rdata,
  output logic              rom_we,
`ifdef IFETCH_PROG_EN
  input  logic              upg_wen_i,
  input  logic [ROM_AW:0]   upg_adr_i,
  input  logic [31:0]       upg_dat_i,
  input  logic              upg_done_i,
`endif
  output logic [31:0]       rom_wdata
);

  localparam int CW = ptr_w(QDEPTH) + 1;
  localparam logic [CW:0] QD = (CW+1)'(QDEPTH);
  localparam int EW = 32 + ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              inflight_q, inflight_d;
  logic              halted_q, halted_d;
  logic              run_q, run_d;

  logic              hold;
  logic              deq, issue, push, flush;
  logic              last_word;
  logic [CW:0]       occ;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_full, fifo_empty;
  logic [EW-1:0]     fifo_dout;
  logic [ADDR_W-1:0] head_pc;
  logic [31:0]       head_data;

`ifdef IFETCH_PROG_EN
  logic prog_hold;
  assign prog_hold = ~upg_done_i;
  assign hold      = ~inited | prog_hold;
  assign rom_we    = prog_hold & upg_wen_i & ~upg_adr_i[ROM_AW];
  assign rom_addr  = prog_hold ? upg_adr_i[ROM_AW-1:0]
                               : pc_q[ROM_AW+1:2];
  assign rom_wdata = prog_hold ? upg_dat_i : ZeroWord;
`else
  assign hold      = ~inited;
  assign rom_we    = 1'b0;
  assign rom_addr  = pc_q[ROM_AW+1:2];
  assign rom_wdata = ZeroWord;
`endif

  assign {head_pc, head_data} = fifo_dout;
  assign inst_valid = ~fifo_empty & ~hold;
  assign inst_data  = inst_valid ? head_data : ZeroWord;
  assign inst_pc    = inst_valid ? head_pc : RESET_PC;
  assign inst_link  = inst_pc + ADDR_W'(4);
  assign last_word  = &pc_q[ROM_AW+1:2];

  // occupancy once this cycle's return and handoff have settled
  always_comb begin
    deq   = inst_valid & dec_ready;
    occ   = {1'b0, fifo_cnt} + (CW+1)'(inflight_q)
          - (CW+1)'(deq);
    issue = run_q & ~hold & ~halted_q & ~redirect_valid
          & (occ < QD);
    flush = redirect_valid | hold;
    push  = inflight_q & ~flush & (~fifo_full | deq);
  end

  assign rom_en = issue;

  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    halted_d   = halted_q;
    inflight_d = issue;
    run_d      = 1'b1;
    if (hold) begin
      pc_d       = RESET_PC;
      halted_d   = 1'b0;
      inflight_d = 1'b0;
      run_d      = 1'b0;
    end else if (redirect_valid) begin
      pc_d     = redirect_pc & ~ADDR_W'(3);
      halted_d = 1'b0;
    end else if (issue) begin
      tag_d = pc_q;
      if (last_word) halted_d = 1'b1;
      else           pc_d     = pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      tag_q      <= RESET_PC;
      inflight_q <= 1'b0;
      halted_q   <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      halted_q   <= halted_d;
      run_q      <= run_d;
    end
  end

  inst_fifo #(
    .W     (EW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .flush_i (flush),
    .push_i  (push),
    .data_i  ({tag_q, rom_rdata}),
    .pop_i   (deq),
    .data_o  (fifo_dout),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed self-checking bench for ifetch_prefetch with a 1-cycle ROM model.
// Programming-port checks run when IFETCH_PROG_EN is defined.
module tb_ifetch_prefetch;

  localparam int AW = 32;
  localparam int RW = 14;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          inited = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          dec_ready = 1'b0;
  logic          inst_valid;
  logic [31:0]   inst_data;
  logic [AW-1:0] inst_pc;
  logic [AW-1:0] inst_link;
  logic          rom_en;
  logic [RW-1:0] rom_addr;
  logic [31:0]   rom_rdata = '0;
  logic          rom_we;
  logic [31:0]   rom_wdata;
`ifdef IFETCH_PROG_EN
  logic          upg_wen_i = 1'b0;
  logic [RW:0]   upg_adr_i = '0;
  logic [31:0]   upg_dat_i = '0;
  logic          upg_done_i = 1'b1;
`endif

  logic [31:0] rom [0:(1<<RW)-1];
  int n_cmp = 0;
  int n_bad = 0;
  logic ovf = 1'b0;

  ifetch_prefetch #(
    .ADDR_W (AW),
    .ROM_AW (RW),
    .QDEPTH (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .inited         (inited),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_link      (inst_link),
    .rom_en         (rom_en),
    .rom_addr       (rom_addr),
    .rom_rdata      (rom_rdata),
    .rom_we         (rom_we),
`ifdef IFETCH_PROG_EN
    .upg_wen_i      (upg_wen_i),
    .upg_adr_i      (upg_adr_i),
    .upg_dat_i      (upg_dat_i),
    .upg_done_i     (upg_done_i),
`endif
    .rom_wdata      (rom_wdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rom_we) rom[rom_addr] <= rom_wdata;
    if (rom_en) rom_rdata <= rom[rom_addr];
  end

  always @(posedge clock) begin
    if (!reset && !dut.hold && dut.inflight_q && dut.fifo_full
        && !dut.deq && !redirect_valid)
      ovf = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // leaves the bench in cycle 0 (first cycle out of reset)
  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    inited = 1'b1;
    redirect_valid = 1'b0;
    dec_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    dec_ready = rdy;
  endtask

  // redirect held for one cycle; returns 1ns into cycle R+1
  task automatic redir(input logic [AW-1:0] a);
    redirect_valid = 1'b1;
    redirect_pc = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < (1 << RW); k++) rom[k] = k;

    repeat (2) @(posedge clock);
    #2;
    chk("rst_valid", inst_valid, 0);
    chk("rst_romen", rom_en, 0);
    chk("rst_romwe", rom_we, 0);
    chk("rst_data", inst_data, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_link", inst_link, 4);

    // straight-line streaming from reset
    reset = 1'b0;
    dec_ready = 1'b1;
    #1;
    chk("c0_romen", rom_en, 0);
    tick(); #1;
    chk("c1_romen", rom_en, 1);
    chk("c1_addr", rom_addr, 0);
    tick(); #1;
    chk("c2_valid", inst_valid, 0);
    tick(); #1;
    for (int i = 0; i < 6; i++) begin
      chk("str_valid", inst_valid, 1);
      chk("str_pc", inst_pc, 4 * i);
      chk("str_data", inst_data, i);
      chk("str_link", inst_link, 4 * i + 4);
      tick(); #1;
    end

    // stall fills the queue, release drains in order
    do_reset(1'b0);
    for (int c = 1; c <= 12; c++) begin
      tick(); #1;
      if (c >= 6) chk("stall_romen", rom_en, 0);
    end
    chk("stall_cnt", dut.fifo_cnt, 4);
    chk("stall_valid", inst_valid, 1);
    chk("stall_pc", inst_pc, 0);
    dec_ready = 1'b1;
    #1;
    chk("rec_romen", rom_en, 1);
    chk("rec_addr", rom_addr, 4);
    for (int i = 0; i < 8; i++) begin
      chk("drain_pc", inst_pc, 4 * i);
      chk("drain_data", inst_data, i);
      tick(); #1;
    end

    // redirect with 3 queued and one read in flight
    do_reset(1'b0);
    repeat (5) tick();
    #1;
    chk("pre_cnt", dut.fifo_cnt, 3);
    chk("pre_inflight", dut.inflight_q, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    #1;
    chk("rd_romen", rom_en, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("rd1_romen", rom_en, 1);
    chk("rd1_addr", rom_addr, 32'h10);
    chk("rd1_valid", inst_valid, 0);
    tick(); #1;
    chk("rd2_valid", inst_valid, 0);
    tick(); #1;
    chk("rd3_valid", inst_valid, 1);
    chk("rd3_pc", inst_pc, 32'h40);
    chk("rd3_data", inst_data, 32'h10);
    dec_ready = 1'b1;
    tick(); #1;
    chk("rd4_pc", inst_pc, 32'h44);
    tick(); #1;
    chk("rd5_pc", inst_pc, 32'h48);

    // misaligned target is word-aligned
    redir(32'h43);
    repeat (2) tick();
    #1;
    chk("mis_pc", inst_pc, 32'h40);
    chk("mis_data", inst_data, 32'h10);

    // last ROM word is fetched once, then the unit halts
    redir(32'hFFFC);
    #1;
    chk("lw1_addr", rom_addr, 14'h3FFF);
    chk("lw1_romen", rom_en, 1);
    tick(); #1;
    chk("lw2_romen", rom_en, 0);
    tick(); #1;
    chk("lw3_valid", inst_valid, 1);
    chk("lw3_pc", inst_pc, 32'hFFFC);
    chk("lw3_data", inst_data, 32'h3FFF);
    chk("lw3_link", inst_link, 32'h10000);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      chk("halt_valid", inst_valid, 0);
      chk("halt_romen", rom_en, 0);
    end
    redir(32'h0);
    #1;
    chk("res_romen", rom_en, 1);
    chk("res_addr", rom_addr, 0);
    repeat (2) tick();
    #1;
    chk("res_pc", inst_pc, 0);
    chk("res_data", inst_data, 0);

    // asynchronous reset with two queued entries
    do_reset(1'b0);
    repeat (4) tick();
    #1;
    chk("ar_cnt", dut.fifo_cnt, 2);
    chk("ar_valid_pre", inst_valid, 1);
    reset = 1'b1;
    #1;
    chk("ar_valid", inst_valid, 0);
    chk("ar_romen", rom_en, 0);
    chk("ar_pc", inst_pc, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    dec_ready = 1'b1;
    repeat (3) tick();
    #1;
    chk("ar3_valid", inst_valid, 1);
    chk("ar3_pc", inst_pc, 0);

    // inited low holds the reset state
    repeat (3) tick();
    inited = 1'b0;
    #1;
    chk("ini_valid", inst_valid, 0);
    chk("ini_romen", rom_en, 0);
    tick();
    inited = 1'b1;
    #1;
    chk("ini0_romen", rom_en, 0);
    repeat (2) tick();
    #1;
    chk("ini2_valid", inst_valid, 0);
    tick(); #1;
    chk("ini3_valid", inst_valid, 1);
    chk("ini3_pc", inst_pc, 0);
    chk("ini3_data", inst_data, 0);

`ifdef IFETCH_PROG_EN
    tick();
    upg_done_i = 1'b0;
    upg_wen_i = 1'b1;
    upg_adr_i = 15'd5;
    upg_dat_i = 32'hDEADBEEF;
    #1;
    chk("pg_we", rom_we, 1);
    chk("pg_addr", rom_addr, 5);
    chk("pg_wdata", rom_wdata, 32'hDEADBEEF);
    chk("pg_romen", rom_en, 0);
    chk("pg_valid", inst_valid, 0);
    tick();
    upg_adr_i = {1'b1, 14'd6};
    #1;
    chk("pg_hi_we", rom_we, 0);
    tick();
    upg_wen_i = 1'b0;
    upg_done_i = 1'b1;
    tick();
    redir(32'h14);
    repeat (2) tick();
    #1;
    chk("pg_pc", inst_pc, 32'h14);
    chk("pg_data", inst_data, 32'hDEADBEEF);
    chk("pg_keep", rom[6], 6);
`endif

    chk("no_enq_full", ovf, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
